eth_rx_fcs_check: RTL
=====================

// Module: eth_rx_fcs_check
// PURPOSE
//  Sits directly downstream of the RMII receive deserialiser on the 50 MHz RMII clock.
//  Consumes its byte stream (data/valid plus a one-cycle eop strobe).
//  Re-emits frame bytes with the 4-byte FCS stripped and marks the first byte with sop.
//  Ends every frame with a status strobe: CRC-32 result, byte count, runt/oversize flags.
//  Feeds the MAC receive FIFO / packet buffer.
// PARAMETERS
//  MIN_LEN  64    min legal frame bytes incl. FCS; fewer -> out_runt
//  MAX_LEN  1518  max legal frame bytes incl. FCS; more -> out_long
//  LEN_W    11    width of byte counter / out_len; counter saturates at 2**LEN_W-1
// PORTS
//  clk50      in   1      RMII reference clock; the only clock
//  reset      in   1      asynchronous, active-high reset
//  in_data    in   8      received byte, valid when in_valid
//  in_valid   in   1      one byte of current frame this cycle
//  in_eop     in   1      1-cycle pulse after the last byte of a frame (never with in_valid upstream)
//  out_data   out  8      payload byte (FCS removed)
//  out_valid  out  1      out_data valid this cycle
//  out_sop    out  1      with out_valid on first payload byte of a frame
//  out_eop    out  1      1-cycle end-of-frame status strobe, never with out_valid
//  out_crc_ok out  1      valid with out_eop: CRC residue matched
//  out_runt   out  1      valid with out_eop: len < MIN_LEN
//  out_long   out  1      valid with out_eop: len > MAX_LEN
//  out_len    out  LEN_W  valid with out_eop: bytes received incl. FCS (saturating)
// BEHAVIOUR
//  - Reset: all outputs 0; state IDLE; delay line, counter cleared; CRC reg = 32'hFFFFFFFF.
//  - Delay line: 4-byte shift register. Input byte k (0-based) enters on its in_valid cycle.
//    For k>=4, byte k-4 appears registered on out_data/out_valid the following cycle.
//    The 4 bytes left in the line at eop are the FCS and are discarded.
//  - FSM: IDLE -(in_valid)-> FILL (count 1..4, no output) -(4th byte in)-> PASS.
//    PASS emits one byte per in_valid; first emitted byte carries out_sop.
//    Any state -(in_eop)-> IDLE with out_eop pulsed next cycle.
//  - CRC: reflected CRC-32, poly 0xEDB88320, init 0xFFFFFFFF, no final xor, LSB first.
//    Updated on every in_valid byte including FCS. out_crc_ok = (reg == 32'hDEBB20E3) at eop.
//    Reg reloaded to init when out_eop fires.
//  - Length: out_len = bytes counted; out_runt/out_long compare it against MIN_LEN/MAX_LEN.
//  - Short frames (<=4 bytes, incl. 0): no out_sop/out_valid; out_eop still fires.
//    out_crc_ok=0 unless residue matches; out_runt=1.
//  - in_eop in IDLE with no bytes: out_eop, out_len=0, out_runt=1, out_crc_ok=0.
//  - in_valid and in_eop same cycle (protocol violation): eop wins, byte dropped.
//  - Frames back-to-back: byte arriving cycle after in_eop starts a new frame normally.
//  - Mid-frame reset: everything cleared. Bytes after release form a new frame.
//    That frame ends with out_crc_ok=0; no recovery of the old frame.
//  - Status fields held stable until the next out_eop.
// CONFIGURATION
//  ETH_RX_FCS_STATS_EN defined:
//    adds out ports stat_good[31:0] and stat_bad[31:0].
//    On each out_eop, stat_good +1 if crc_ok & !runt & !long, else stat_bad +1.
//    Counters wrap at 2**32, reset to 0.
//  ETH_RX_FCS_STATS_EN undefined: ports and counters absent; all other behaviour identical.
// STRUCTURE
//  eth_pkg: CRC32_POLY_REFL, CRC32_INIT, CRC32_RESIDUE constants;
//    function crc32_byte(crc, byte); fsm state typedef.
//  Sub-module eth_crc32: 32-bit reg with init/enable ports using eth_pkg::crc32_byte.
//  Shared later by the TX FCS generator.
// TESTING
//  1. Bytes "123456789" + 26 39 F4 CB, MIN_LEN=64 ->
//     out_data 31..39 with sop on 0x31; eop: crc_ok=1, len=13, runt=1, long=0.
//  2. Same frame, bit 0 of byte 5 flipped -> crc_ok=0, len=13, payload shows flipped byte.
//  3. 60-byte payload + model-generated FCS (64 total) -> 60 out bytes;
//     eop: crc_ok=1, len=64, runt=0, long=0. With STATS: stat_good=1.
//  4. 1519-byte good frame -> long=1, len=1519. 2100-byte frame -> len=2047 (saturated).
//  5. in_eop with 0 bytes, then 3-byte frame -> two out_eop, no out_valid;
//     len=0 then 3, runt=1.
//  6. Reset asserted after byte 20 of good frame, released, 30 more bytes + eop ->
//     outputs 0 during reset; final eop crc_ok=0, len=30.

Source files
------------

// File: rtl/eth_pkg.sv
// Shared Ethernet CRC-32 constants, byte-wise CRC update and receive FSM state type.
package eth_pkg;

  localparam logic [31:0] CRC32_POLY_REFL = 32'hEDB88320;
  localparam logic [31:0] CRC32_INIT      = 32'hFFFFFFFF;
  localparam logic [31:0] CRC32_RESIDUE   = 32'hDEBB20E3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_PASS = 2'd2
  } rx_state_t;

  // Reflected CRC-32, one byte consumed LSB first, no final inversion.
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    c = crc ^ {24'h0, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC32_POLY_REFL) : (c >> 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/eth_crc32.sv
// Running CRC-32 register with synchronous reload and byte enable; reused by the TX FCS path.
module eth_crc32
  import eth_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_init,
  input  logic        i_en,
  input  logic [7:0]  i_data,
  output logic [31:0] o_crc
);

  logic [31:0] r_crc;

  // Reload has priority so a byte colliding with a reload is dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_crc <= CRC32_INIT;
    end else if (i_init) begin
      r_crc <= CRC32_INIT;
    end else if (i_en) begin
      r_crc <= crc32_byte(r_crc, i_data);
    end
  end

  assign o_crc = r_crc;

endmodule

// File: rtl/eth_rx_fcs_check.sv
// RMII receive FCS checker: strips the 4-byte FCS, tags sop, reports CRC/length status at eop.
// Optional ETH_RX_FCS_STATS_EN adds good/bad frame counters (stat_good, stat_bad).
module eth_rx_fcs_check
  import eth_pkg::*;
#(
  parameter int MIN_LEN = 64,
  parameter int MAX_LEN = 1518,
  parameter int LEN_W   = 11
) (
  input  logic             clk50,
  input  logic             reset,
  input  logic [7:0]       in_data,
  input  logic             in_valid,
  input  logic             in_eop,
  output logic [7:0]       out_data,
  output logic             out_valid,
  output logic             out_sop,
  output logic             out_eop,
  output logic             out_crc_ok,
  output logic             out_runt,
  output logic             out_long,
  output logic [LEN_W-1:0] out_len
`ifdef ETH_RX_FCS_STATS_EN
  ,
  output logic [31:0]      stat_good,
  output logic [31:0]      stat_bad
`endif
);

  localparam logic [LEN_W-1:0] CNT_MAX = '1;
  localparam logic [LEN_W-1:0] MIN_L   = LEN_W'(MIN_LEN);
  localparam logic [LEN_W-1:0] MAX_L   = LEN_W'(MAX_LEN);

  rx_state_t        r_state;
  logic [LEN_W-1:0] r_cnt;
  logic [3:0][7:0]  r_dly;
  logic             r_first;

  logic [31:0] w_crc;
  logic        w_byte;
  logic        w_crc_ok;
  logic        w_runt;
  logic        w_long;

  // eop wins over a simultaneous byte, which is then neither counted nor hashed.
  assign w_byte   = in_valid & ~in_eop;
  assign w_crc_ok = (w_crc == CRC32_RESIDUE);
  assign w_runt   = (r_cnt < MIN_L);
  assign w_long   = (r_cnt > MAX_L);

  eth_crc32 u_crc (
    .clk    (clk50),
    .rst    (reset),
    .i_init (in_eop),
    .i_en   (w_byte),
    .i_data (in_data),
    .o_crc  (w_crc)
  );

  always_ff @(posedge clk50 or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_dly      <= '0;
      r_first    <= 1'b0;
      out_data   <= '0;
      out_valid  <= 1'b0;
      out_sop    <= 1'b0;
      out_eop    <= 1'b0;
      out_crc_ok <= 1'b0;
      out_runt   <= 1'b0;
      out_long   <= 1'b0;
      out_len    <= '0;
    end else begin
      out_valid <= 1'b0;
      out_sop   <= 1'b0;
      out_eop   <= 1'b0;
      if (in_eop) begin
        out_eop    <= 1'b1;
        out_crc_ok <= w_crc_ok;
        out_runt   <= w_runt;
        out_long   <= w_long;
        out_len    <= r_cnt;
        r_cnt      <= '0;
        r_dly      <= '0;
        r_first    <= 1'b0;
        r_state    <= ST_IDLE;
      end else if (in_valid) begin
        r_dly <= {r_dly[2:0], in_data};
        if (r_cnt != CNT_MAX) r_cnt <= r_cnt + 1'b1;
        // r_cnt doubles as the fill counter: the 4th byte arrives with r_cnt == 3.
        case (r_state)
          ST_IDLE: r_state <= ST_FILL;
          ST_FILL: begin
            if (r_cnt == LEN_W'(3)) begin
              r_state <= ST_PASS;
              r_first <= 1'b1;
            end
          end
          ST_PASS: begin
            out_valid <= 1'b1;
            out_sop   <= r_first;
            out_data  <= r_dly[3];
            r_first   <= 1'b0;
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

`ifdef ETH_RX_FCS_STATS_EN
  always_ff @(posedge clk50 or posedge reset) begin
    if (reset) begin
      stat_good <= '0;
      stat_bad  <= '0;
    end else if (in_eop) begin
      if (w_crc_ok && !w_runt && !w_long) stat_good <= stat_good + 32'd1;
      else                                stat_bad  <= stat_bad + 32'd1;
    end
  end
`endif

endmodule
